alarm_seq_ctrl: RTL and testbench

- Alarm sequencing controller between the min/sec match logic and the buzzer melody generator.
- Turns a time-match level into a timed ring session with snooze, stop and auto-timeout, and drives the buzzer enable.
- Exposes state and the snooze countdown so the display can show remaining snooze time.
- All timing is counted in 1 Hz tick pulses from the system-clock domain.

---
 rtl/alarm_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_alarm_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_seq_ctrl
// Purpose  : Turns an alarm time-match level into a timed ring session with
//            snooze, stop and auto-timeout; drives the buzzer enable.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_seq_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_match,
    input  logic       i_alarm_en,
    input  logic       i_snooze,
    input  logic       i_stop,
    output logic       o_buzz_en,
    output logic [1:0] o_state,
    output logic [8:0] o_snooze_remain,
    output logic [1:0] o_snooze_cnt
);

    localparam logic [8:0] c_RING_LAST  = 9'(RING_SEC - 1);
    localparam logic [8:0] c_SNOOZE_LEN = 9'(SNOOZE_SEC);
    localparam logic [1:0] c_MAX_SNOOZE = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    state_t     r_state;
    logic [8:0] r_ring_tmr;
    logic [8:0] r_remain;
    logic [1:0] r_snooze_cnt;
    logic       r_match_d;

    state_t     w_state_nxt;
    logic [8:0] w_ring_tmr_nxt;
    logic [8:0] w_remain_nxt;
    logic [1:0] w_snooze_cnt_nxt;
    logic       w_trig;
    logic       w_can_snooze;
    logic       w_timeout;

    assign w_trig       = i_match & ~r_match_d;
    assign w_can_snooze = (r_snooze_cnt < c_MAX_SNOOZE);
    assign w_timeout    = i_tick & (r_ring_tmr == c_RING_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ring_tmr   <= '0;
            r_remain     <= '0;
            r_snooze_cnt <= '0;
            // Starts high so a match already present at reset release is not an edge
            r_match_d    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_tmr   <= w_ring_tmr_nxt;
            r_remain     <= w_remain_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_match_d    <= i_match;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ring_tmr_nxt   = r_ring_tmr;
        w_remain_nxt     = r_remain;
        w_snooze_cnt_nxt = r_snooze_cnt;

        if (!i_alarm_en) begin
            w_state_nxt      = ST_IDLE;
            w_ring_tmr_nxt   = '0;
            w_remain_nxt     = '0;
            w_snooze_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        w_state_nxt      = ST_RING;
                        w_ring_tmr_nxt   = '0;
                        w_snooze_cnt_nxt = '0;
                    end
                end
                ST_RING: begin
                    if (i_stop) begin
                        w_state_nxt      = ST_IDLE;
                        w_ring_tmr_nxt   = '0;
                        w_snooze_cnt_nxt = '0;
                    end else if ((i_snooze || w_timeout) && w_can_snooze) begin
                        // A snooze press coinciding with the timeout tick is one snooze
                        w_state_nxt      = ST_SNOOZE;
                        w_ring_tmr_nxt   = '0;
                        w_remain_nxt     = c_SNOOZE_LEN;
                        w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
                    end else if (w_timeout) begin
                        w_state_nxt      = ST_IDLE;
                        w_ring_tmr_nxt   = '0;
                        w_snooze_cnt_nxt = '0;
                    end else if (i_tick) begin
                        w_ring_tmr_nxt   = r_ring_tmr + 9'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (i_stop) begin
                        w_state_nxt      = ST_IDLE;
                        w_remain_nxt     = '0;
                        w_snooze_cnt_nxt = '0;
                    end else if (i_tick) begin
                        if (r_remain > 9'd1) begin
                            w_remain_nxt = r_remain - 9'd1;
                        end else begin
                            w_state_nxt    = ST_RING;
                            w_remain_nxt   = '0;
                            w_ring_tmr_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt      = ST_IDLE;
                    w_ring_tmr_nxt   = '0;
                    w_remain_nxt     = '0;
                    w_snooze_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign o_buzz_en       = (r_state == ST_RING);
    assign o_state         = r_state;
    assign o_snooze_remain = r_remain;
    assign o_snooze_cnt    = r_snooze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_seq_ctrl
// Purpose  : Directed plus randomized bench for alarm_seq_ctrl against a
//            session-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_seq_ctrl;

    localparam int c_RING   = 3;
    localparam int c_SNOOZE = 5;
    localparam int c_MAXS   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_match = 1'b0;
    logic       i_alarm_en = 1'b0;
    logic       i_snooze = 1'b0;
    logic       i_stop = 1'b0;
    logic       o_buzz_en;
    logic [1:0] o_state;
    logic [8:0] o_snooze_remain;
    logic [1:0] o_snooze_cnt;

    int n_cmp = 0;
    int n_err = 0;

    alarm_seq_ctrl #(
        .RING_SEC  (c_RING),
        .SNOOZE_SEC(c_SNOOZE),
        .MAX_SNOOZE(c_MAXS)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_tick         (i_tick),
        .i_match        (i_match),
        .i_alarm_en     (i_alarm_en),
        .i_snooze       (i_snooze),
        .i_stop         (i_stop),
        .o_buzz_en      (o_buzz_en),
        .o_state        (o_state),
        .o_snooze_remain(o_snooze_remain),
        .o_snooze_cnt   (o_snooze_cnt)
    );

    always #5 clk = ~clk;

    // Session model: mode 0 idle, 1 ringing, 2 snoozing
    int m_mode   = 0;
    int m_rung   = 0;   // ticks rung so far in this ring period
    int m_left   = 0;   // snooze ticks left
    int m_used   = 0;   // snoozes taken this session
    bit m_prev   = 1'b1;

    task automatic m_end_session();
        m_mode = 0; m_rung = 0; m_left = 0; m_used = 0;
    endtask

    task automatic m_begin_snooze();
        m_mode = 2; m_rung = 0; m_left = c_SNOOZE; m_used = m_used + 1;
    endtask

    always @(posedge clk) begin
        bit rise;
        rise   = i_match && !m_prev;
        m_prev = i_match;
        if (!rst_n) begin
            m_end_session();
            m_prev = 1'b1;
        end else if (!i_alarm_en) begin
            m_end_session();
        end else if (m_mode == 0) begin
            if (rise) begin m_mode = 1; m_rung = 0; m_used = 0; end
        end else if (m_mode == 1) begin
            bit times_up;
            times_up = i_tick && (m_rung + 1 == c_RING);
            if (i_stop)
                m_end_session();
            else if ((i_snooze || times_up) && m_used < c_MAXS)
                m_begin_snooze();
            else if (times_up)
                m_end_session();
            else if (i_tick)
                m_rung++;
        end else begin
            if (i_stop)
                m_end_session();
            else if (i_tick) begin
                if (m_left == 1) begin m_mode = 1; m_left = 0; m_rung = 0; end
                else m_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (o_state != 2'(m_mode) || o_buzz_en != (m_mode == 1) ||
                o_snooze_remain != 9'(m_left) || o_snooze_cnt != 2'(m_used)) begin
                n_err++;
                $display("FAIL model t=%0t: got st=%0d bz=%0d rem=%0d cnt=%0d, want st=%0d bz=%0d rem=%0d cnt=%0d",
                         $time, o_state, o_buzz_en, o_snooze_remain, o_snooze_cnt,
                         m_mode, (m_mode == 1), m_left, m_used);
            end
        end
    end

    task automatic expect_out(input string name, input int st, input int bz,
                              input int rem, input int cnt);
        n_cmp++;
        if (o_state != 2'(st) || o_buzz_en != 1'(bz) ||
            o_snooze_remain != 9'(rem) || o_snooze_cnt != 2'(cnt)) begin
            n_err++;
            $display("FAIL %s: got st=%0d bz=%0d rem=%0d cnt=%0d, want st=%0d bz=%0d rem=%0d cnt=%0d",
                     name, o_state, o_buzz_en, o_snooze_remain, o_snooze_cnt, st, bz, rem, cnt);
        end
    endtask

    // Apply one cycle of pulses; returns at posedge+2 with pulses cleared
    task automatic cyc(input bit t, input bit s, input bit p);
        i_tick = t; i_snooze = s; i_stop = p;
        @(posedge clk); #2;
        i_tick = 1'b0; i_snooze = 1'b0; i_stop = 1'b0;
    endtask

    task automatic tick10();
        repeat (9) cyc(0, 0, 0);
        cyc(1, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        expect_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0);
    endtask

    initial begin
        i_alarm_en = 1'b1;
        do_reset();
        expect_out("idle_after_reset", 0, 0, 0, 0);

        // Trigger and auto-snooze on the third tick
        i_match = 1'b1; cyc(0, 0, 0);
        expect_out("trigger_ring", 1, 1, 0, 0);
        tick10(); tick10();
        expect_out("ring_two_ticks", 1, 1, 0, 0);
        tick10();
        expect_out("timeout_snooze", 2, 0, 5, 1);
        i_match = 1'b0;

        // Snooze countdown back to ring
        for (int k = 4; k >= 1; k--) begin
            tick10();
            expect_out("snooze_count", 2, 0, k, 1);
        end
        tick10();
        expect_out("snooze_expire", 1, 1, 0, 1);

        // Manual snooze, then limit reached
        cyc(0, 1, 0);
        expect_out("manual_snooze", 2, 0, 5, 2);
        repeat (5) tick10();
        expect_out("second_ring", 1, 1, 0, 2);
        cyc(0, 1, 0);
        expect_out("snooze_ignored", 1, 1, 0, 2);
        tick10(); tick10();
        expect_out("still_ring", 1, 1, 0, 2);
        tick10();
        expect_out("final_timeout", 0, 0, 0, 0);

        // Match held through reset release must not trigger
        i_match = 1'b1;
        do_reset();
        cyc(0, 0, 0);
        expect_out("held_match_no_trig", 0, 0, 0, 0);
        i_match = 1'b0; cyc(0, 0, 0);
        i_match = 1'b1; cyc(0, 0, 0);
        expect_out("fresh_rise_trig", 1, 1, 0, 0);

        // Match re-rise during ring does not restart the ring timer
        tick10();
        i_match = 1'b0; cyc(0, 0, 0);
        i_match = 1'b1; cyc(0, 0, 0);
        expect_out("rerise_ignored", 1, 1, 0, 0);
        tick10();
        expect_out("ring_tick2", 1, 1, 0, 0);
        tick10();
        expect_out("orig_timeout", 2, 0, 5, 1);

        // Stop and expiry tick together: stop wins
        repeat (4) tick10();
        expect_out("remain_one", 2, 0, 1, 1);
        cyc(1, 0, 1);
        expect_out("stop_beats_expiry", 0, 0, 0, 0);

        // De-arming during ring
        i_match = 1'b0; cyc(0, 0, 0);
        i_match = 1'b1; cyc(0, 0, 0);
        expect_out("retrigger", 1, 1, 0, 0);
        i_alarm_en = 1'b0; cyc(0, 0, 0);
        expect_out("disarm", 0, 0, 0, 0);
        i_alarm_en = 1'b1;

        // Randomized traffic checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            i_alarm_en = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) i_match = ~i_match;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
